serial_dft_multibin: RTL and testbench

SERIAL_DFT_MULTIBIN -- requirements
Module: serial_dft_multibin

---
 rtl/serial_dft_multibin.sv | 239 +++++++++++++++++++++++
 tb/tb_serial_dft_multibin.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_dft_multibin.sv
// serial_dft_multibin
//   Streaming multi-bin DFT. Each accepted sample x is multiplied by a
//   per-bin, per-index complex weight and accumulated with saturation.
//   When a frame completes, the N_BINS results go into an output buffer,
//   and a small IDLE/SEND FSM presents them one bin at a time under a
//   valid/ready handshake.
// Ports:
//   clk, arstn        clock, asynchronous active-low reset
//   w_re, w_im        [N_BINS][FRAME_LENGTH] signed weights (quasi-static)
//   valid_i, sof_i, x sample strobe, start-of-frame, signed sample
//   ready_i           downstream accepts the presented result
//   valid_o, bin_o    result present, bin index of result
//   re, im, sat_o     signed result, bin saturated during its frame
//   overrun_o         sticky: a completed frame was dropped

// Per-bin accumulator. re_o/im_o/sat_o are the running totals that include
// the current sample. The top module captures them on the last sample.
module serial_dft_bin #(
    parameter int W_WIDTH = 16,
    parameter int X_WIDTH = 16,
    parameter int S_WIDTH = 40
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      valid_i,
    input  logic                      sof_i,
    input  logic                      last_i,
    input  logic signed [X_WIDTH-1:0] x_i,
    input  logic signed [W_WIDTH-1:0] w_re_i,
    input  logic signed [W_WIDTH-1:0] w_im_i,
    output logic signed [S_WIDTH-1:0] re_o,
    output logic signed [S_WIDTH-1:0] im_o,
    output logic                      sat_o
);
    localparam int PW = X_WIDTH + W_WIDTH;
    // The adder is wide enough that neither operand nor the sum can wrap.
    // The product may be wider than the accumulator.
    localparam int AW = ((S_WIDTH > PW) ? S_WIDTH : PW) + 1;

    // Returns {saturated, clamped_sum}.
    function automatic logic [S_WIDTH:0] sat_add(input logic signed [S_WIDTH-1:0] a,
                                                 input logic signed [PW-1:0] p);
        logic signed [AW-1:0] s;
        s = AW'(a) + AW'(p);
        // The sum fits when every bit from the S_WIDTH sign bit upward is equal.
        if ((&s[AW-1:S_WIDTH-1]) || !(|s[AW-1:S_WIDTH-1]))
            return {1'b0, s[S_WIDTH-1:0]};
        else if (s[AW-1])
            return {1'b1, 1'b1, {(S_WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(S_WIDTH-1){1'b1}}};
    endfunction

    logic signed [S_WIDTH-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic                      sat_q, sat_d;
    logic signed [S_WIDTH-1:0] base_re, base_im;
    logic                      base_sat;
    logic signed [PW-1:0]      p_re, p_im;
    logic        [S_WIDTH:0]   sr, si;

    always_comb begin
        // A start-of-frame sample accumulates from zero and ignores old state.
        base_re  = sof_i ? '0 : acc_re_q;
        base_im  = sof_i ? '0 : acc_im_q;
        base_sat = sof_i ? 1'b0 : sat_q;
        p_re     = PW'(x_i) * PW'(w_re_i);
        p_im     = PW'(x_i) * PW'(w_im_i);
        sr       = sat_add(base_re, p_re);
        si       = sat_add(base_im, p_im);
        re_o     = sr[S_WIDTH-1:0];
        im_o     = si[S_WIDTH-1:0];
        sat_o    = base_sat | sr[S_WIDTH] | si[S_WIDTH];

        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        sat_d    = sat_q;
        if (valid_i) begin
            if (last_i) begin
                acc_re_d = '0;
                acc_im_d = '0;
                sat_d    = 1'b0;
            end else begin
                acc_re_d = re_o;
                acc_im_d = im_o;
                sat_d    = sat_o;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            sat_q    <= sat_d;
        end
    end
endmodule

module serial_dft_multibin #(
    parameter int W_WIDTH      = 16,
    parameter int X_WIDTH      = 16,
    parameter int S_WIDTH      = 40,
    parameter int FRAME_LENGTH = 180,
    parameter int N_BINS       = 4,
    localparam int BW = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
    input  logic                                                clk,
    input  logic                                                arstn,
    input  logic signed [N_BINS-1:0][FRAME_LENGTH-1:0][W_WIDTH-1:0] w_re,
    input  logic signed [N_BINS-1:0][FRAME_LENGTH-1:0][W_WIDTH-1:0] w_im,
    input  logic                                                valid_i,
    input  logic                                                sof_i,
    input  logic signed [X_WIDTH-1:0]                           x,
    input  logic                                                ready_i,
    output logic                                                valid_o,
    output logic [BW-1:0]                                       bin_o,
    output logic signed [S_WIDTH-1:0]                           re,
    output logic signed [S_WIDTH-1:0]                           im,
    output logic                                                sat_o,
    output logic                                                overrun_o
);
    localparam int CW = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [BW-1:0]             bin_q, bin_d;
    logic                      overrun_q, overrun_d;
    logic signed [S_WIDTH-1:0] buf_re_q [N_BINS];
    logic signed [S_WIDTH-1:0] buf_re_d [N_BINS];
    logic signed [S_WIDTH-1:0] buf_im_q [N_BINS];
    logic signed [S_WIDTH-1:0] buf_im_d [N_BINS];
    logic [N_BINS-1:0]         buf_sat_q, buf_sat_d;

    logic signed [S_WIDTH-1:0] sum_re [N_BINS];
    logic signed [S_WIDTH-1:0] sum_im [N_BINS];
    logic [N_BINS-1:0]         sum_sat;

    logic [CW-1:0] idx;
    logic          last, fin_hs, load, drop;

    // A start-of-frame sample is index 0 whatever the counter says.
    assign idx  = sof_i ? '0 : cnt_q;
    assign last = valid_i && (idx == CW'(FRAME_LENGTH - 1));

    for (genvar b = 0; b < N_BINS; b++) begin : g_bin
        serial_dft_bin #(
            .W_WIDTH (W_WIDTH),
            .X_WIDTH (X_WIDTH),
            .S_WIDTH (S_WIDTH)
        ) u_bin (
            .clk     (clk),
            .arstn   (arstn),
            .valid_i (valid_i),
            .sof_i   (sof_i),
            .last_i  (last),
            .x_i     (x),
            .w_re_i  (w_re[b][idx]),
            .w_im_i  (w_im[b][idx]),
            .re_o    (sum_re[b]),
            .im_o    (sum_im[b]),
            .sat_o   (sum_sat[b])
        );
    end

    always_comb begin
        fin_hs = (state_q == SEND) && ready_i && (bin_q == BW'(N_BINS - 1));
        // A completed frame loads if the buffer is free now or is being freed
        // on this same edge. Otherwise the frame is lost.
        load   = last && ((state_q == IDLE) || fin_hs);
        drop   = last && (state_q == SEND) && !fin_hs;

        cnt_d = cnt_q;
        if (valid_i)
            cnt_d = last ? '0 : idx + 1'b1;

        state_d = state_q;
        bin_d   = bin_q;
        if (state_q == SEND && ready_i) begin
            if (bin_q == BW'(N_BINS - 1)) begin
                state_d = IDLE;
                bin_d   = '0;
            end else begin
                bin_d = bin_q + 1'b1;
            end
        end
        if (load) begin
            state_d = SEND;
            bin_d   = '0;
        end

        overrun_d = overrun_q;
        if (valid_i && sof_i) overrun_d = 1'b0;
        if (drop)             overrun_d = 1'b1;

        buf_re_d  = buf_re_q;
        buf_im_d  = buf_im_q;
        buf_sat_d = buf_sat_q;
        if (load) begin
            buf_re_d  = sum_re;
            buf_im_d  = sum_im;
            buf_sat_d = sum_sat;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            overrun_q <= 1'b0;
            buf_sat_q <= '0;
            for (int b = 0; b < N_BINS; b++) begin
                buf_re_q[b] <= '0;
                buf_im_q[b] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            overrun_q <= overrun_d;
            buf_re_q  <= buf_re_d;
            buf_im_q  <= buf_im_d;
            buf_sat_q <= buf_sat_d;
        end
    end

    assign valid_o   = (state_q == SEND);
    assign bin_o     = bin_q;
    assign re        = buf_re_q[bin_q];
    assign im        = buf_im_q[bin_q];
    assign sat_o     = buf_sat_q[bin_q];
    assign overrun_o = overrun_q;
endmodule

// File: tb/tb_serial_dft_multibin.sv
// Directed bench for serial_dft_multibin: FRAME_LENGTH=4, N_BINS=2, S_WIDTH=20.
// Bin 0 weights are w_re=1, w_im=0. Bin 1 weights are w_re=0, w_im=-1.
// The saturation case swaps in w_re=32767 for every bin.
module tb_serial_dft_multibin;
    localparam int WW = 16, XW = 16, SW = 20, FL = 4, NB = 2;

    logic clk = 1'b0;
    logic arstn;
    logic signed [NB-1:0][FL-1:0][WW-1:0] w_re, w_im;
    logic valid_i, sof_i, ready_i;
    logic signed [XW-1:0] x;
    logic valid_o, sat_o, overrun_o;
    logic [0:0] bin_o;
    logic signed [SW-1:0] re, im;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_dft_multibin #(
        .W_WIDTH(WW), .X_WIDTH(XW), .S_WIDTH(SW), .FRAME_LENGTH(FL), .N_BINS(NB)
    ) dut (
        .clk(clk), .arstn(arstn), .w_re(w_re), .w_im(w_im),
        .valid_i(valid_i), .sof_i(sof_i), .x(x), .ready_i(ready_i),
        .valid_o(valid_o), .bin_o(bin_o), .re(re), .im(im),
        .sat_o(sat_o), .overrun_o(overrun_o)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present inputs for one clock and return 1 time unit after the edge.
    task automatic step(input logic v, input logic s, input int xv, input logic r);
        valid_i = v; sof_i = s; x = XW'(xv); ready_i = r;
        @(posedge clk); #1;
    endtask

    // Check every output against the given expected values.
    task automatic chk_out(input string tag, input logic v, input int b,
                           input longint er, input longint ei, input logic es);
        chk({tag, ".valid"}, longint'(valid_o), longint'(v));
        chk({tag, ".bin"},   longint'(bin_o),   longint'(b));
        chk({tag, ".re"},    longint'(re),      er);
        chk({tag, ".im"},    longint'(im),      ei);
        chk({tag, ".sat"},   longint'(sat_o),   longint'(es));
    endtask

    task automatic set_std_weights();
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < FL; i++) begin
                w_re[b][i] = (b == 0) ? 16'sd1 : 16'sd0;
                w_im[b][i] = (b == 0) ? 16'sd0 : -16'sd1;
            end
    endtask

    initial begin
        set_std_weights();
        arstn = 1'b0; valid_i = 0; sof_i = 0; x = '0; ready_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        chk("reset.overrun", longint'(overrun_o), 0);
        arstn = 1'b1;

        // Basic frame with ready held high.
        step(1, 1, 1, 1); step(1, 0, 2, 1); step(1, 0, 3, 1); step(1, 0, 4, 1);
        chk_out("basic.b0", 1, 0, 10, 0, 0);
        step(0, 0, 0, 1);
        chk_out("basic.b1", 1, 1, 0, -10, 0);
        step(0, 0, 0, 1);
        chk("basic.idle", longint'(valid_o), 0);

        // Backpressure: the held bin 0 result stays stable.
        step(1, 1, 1, 0); step(1, 0, 2, 0); step(1, 0, 3, 0); step(1, 0, 4, 0);
        for (int i = 0; i < 5; i++) begin
            chk_out("hold.b0", 1, 0, 10, 0, 0);
            step(0, 0, 0, 0);
        end
        step(0, 0, 0, 1);
        chk_out("hold.b1", 1, 1, 0, -10, 0);
        step(0, 0, 0, 1);
        chk("hold.idle", longint'(valid_o), 0);

        // A mid-frame sof discards the samples before it.
        step(1, 1, 5, 1); step(1, 0, 6, 1);
        step(1, 1, 1, 1); step(1, 0, 1, 1); step(1, 0, 1, 1); step(1, 0, 1, 1);
        chk_out("resof.b0", 1, 0, 4, 0, 0);
        step(0, 0, 0, 1);
        chk_out("resof.b1", 1, 1, 0, -4, 0);
        step(0, 0, 0, 1);

        // Overrun: a second frame completes while the first is still unread.
        step(1, 1, 1, 0); step(1, 0, 2, 0); step(1, 0, 3, 0); step(1, 0, 4, 0);
        chk("ovr.pre", longint'(overrun_o), 0);
        step(1, 0, 2, 0); step(1, 0, 2, 0); step(1, 0, 2, 0); step(1, 0, 2, 0);
        chk("ovr.set", longint'(overrun_o), 1);
        chk_out("ovr.b0", 1, 0, 10, 0, 0);
        step(0, 0, 0, 1);
        chk_out("ovr.b1", 1, 1, 0, -10, 0);
        chk("ovr.sticky", longint'(overrun_o), 1);
        step(0, 0, 0, 1);
        step(1, 1, 1, 1);
        chk("ovr.clear", longint'(overrun_o), 0);
        step(1, 0, 1, 1); step(1, 0, 1, 1); step(1, 0, 1, 1);
        chk_out("ovr.next", 1, 0, 4, 0, 0);

        // The final handshake and the frame completion happen on the same edge.
        step(1, 0, 2, 0);
        step(1, 0, 2, 0);
        step(1, 0, 2, 1);
        chk_out("same.b1", 1, 1, 0, -4, 0);
        step(1, 0, 2, 1);
        chk_out("same.b0", 1, 0, 8, 0, 0);
        chk("same.overrun", longint'(overrun_o), 0);
        step(0, 0, 0, 1);
        chk_out("same.b1new", 1, 1, 0, -8, 0);
        step(0, 0, 0, 1);

        // Asynchronous reset asserted mid-frame and mid-SEND.
        step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0);
        step(1, 1, 7, 1);
        step(1, 0, 7, 0);
        chk_out("prerst.b1", 1, 1, 0, -4, 0);
        #3 arstn = 1'b0;
        #1;
        chk_out("rst.async", 0, 0, 0, 0, 0);
        chk("rst.overrun", longint'(overrun_o), 0);
        #2 arstn = 1'b1;
        // After reset the first sample is index 0 even without sof.
        step(1, 0, 1, 1); step(1, 0, 2, 1); step(1, 0, 3, 1); step(1, 0, 4, 1);
        chk_out("postrst.b0", 1, 0, 10, 0, 0);
        step(0, 0, 0, 1);
        chk_out("postrst.b1", 1, 1, 0, -10, 0);
        step(0, 0, 0, 1);

        // Saturation at the 20-bit maximum, then a clean frame clears sat.
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < FL; i++) begin
                w_re[b][i] = 16'sd32767;
                w_im[b][i] = 16'sd0;
            end
        step(1, 1, 32767, 1); step(1, 0, 32767, 1); step(1, 0, 32767, 1); step(1, 0, 32767, 1);
        chk_out("sat.b0", 1, 0, 524287, 0, 1);
        step(0, 0, 0, 1);
        chk_out("sat.b1", 1, 1, 524287, 0, 1);
        step(0, 0, 0, 1);
        step(1, 1, 1, 1); step(1, 0, 1, 1); step(1, 0, 1, 1); step(1, 0, 1, 1);
        chk_out("nosat.b0", 1, 0, 131068, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("nosat.idle", longint'(valid_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
